// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//
// Packs bytes from the read side of a first-word fall-through FIFO into
// 32-bit little-endian words. A partially filled word is flushed downstream
// once the FIFO has stayed empty for TIMEOUT consecutive cycles. TIMEOUT=0
// disables the flush, and partial bytes are then held until the word fills.
//
// Ports
//   rclk       read-domain clock, rising edge
//   rrst_n     asynchronous active-low reset
//   rempty     FIFO empty flag
//   rdata      FIFO head byte, valid whenever rempty=0
//   rinc       FIFO pop strobe; the head byte is consumed at the edge where rinc=1
//   out_data   packed word; lanes not yet written read 0
//   out_keep   byte-lane valid mask, bit i covers out_data[8i+7:8i]
//   out_valid  word available
//   out_ready  downstream accepts the word
module fifo_rd_packer #(
    parameter int TIMEOUT = 16
) (
    input  logic        rclk,
    input  logic        rrst_n,
    input  logic        rempty,
    input  logic [7:0]  rdata,
    output logic        rinc,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam bit         FLUSH_EN  = (TIMEOUT != 0);
    localparam logic [7:0] IDLE_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  keep_q, keep_d;
    logic        pop;
    logic        flush;

    // A pop only happens while collecting and the FIFO has a byte. Gating
    // with rrst_n keeps the FIFO from being popped while we are held in reset.
    assign pop = (state_q == FILL) && !rempty && rrst_n;

    // Flush fires on the TIMEOUT-th consecutive empty cycle after the last
    // pop: idle_cnt counts the earlier empty edges, so it reads TIMEOUT-1 here.
    assign flush = FLUSH_EN && (state_q == FILL) && (byte_cnt_q != 2'd0)
                   && rempty && (idle_cnt_q == IDLE_LAST);

    assign rinc      = pop;
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_keep  = keep_q;

    // Next-state logic. In FILL each pop drops the byte into the lane chosen
    // by byte_cnt; the fourth pop (or a timeout with a partial word) moves to
    // HOLD. HOLD freezes the word until the downstream accepts it, after which
    // the word register is cleared so unwritten lanes read 0 next time.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        data_d     = data_q;
        keep_d     = keep_q;

        unique case (state_q)
            FILL: begin
                if (pop) begin
                    data_d[{byte_cnt_q, 3'b000} +: 8] = rdata;
                    keep_d[byte_cnt_q]                = 1'b1;
                    idle_cnt_d                        = 8'd0;
                    byte_cnt_d                        = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = HOLD;
                    end
                end else if (byte_cnt_q == 2'd0) begin
                    idle_cnt_d = 8'd0;
                end else if (flush) begin
                    state_d    = HOLD;
                    byte_cnt_d = 2'd0;
                    idle_cnt_d = 8'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                idle_cnt_d = 8'd0;
                if (out_ready) begin
                    state_d = FILL;
                    data_d  = 32'd0;
                    keep_d  = 4'd0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers. Reset discards any partial or pending word.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= FILL;
            byte_cnt_q <= 2'd0;
            idle_cnt_q <= 8'd0;
            data_q     <= 32'd0;
            keep_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
        end
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: rclk is the clock and rrst_n is the reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the flush timeout in rclk cycles; legal range is 0..255, and 0 disables flush.
REQ-003 Port rclk, input, width 1: read-domain clock; all state updates on its rising edge.
REQ-004 Port rrst_n, input, width 1: asynchronous active-low reset.
REQ-005 Port rempty, input, width 1: FIFO empty flag, registered inside the FIFO.
REQ-006 Port rdata, input, width 8: FIFO head byte, first-word fall-through, valid whenever rempty=0.
REQ-007 Port rinc, output, width 1: FIFO pop strobe; the head byte is consumed at the rclk edge where rinc=1.
REQ-008 Port out_data, output, width 32: packed word.
REQ-009 Port out_keep, output, width 4: byte-lane valid mask, bit i covering out_data[8i+7:8i].
REQ-010 Port out_valid, output, width 1: word available.
REQ-011 Port out_ready, input, width 1: downstream accepts the word.

Function
REQ-012 The block SHALL use two states: FILL (collecting bytes) and HOLD (presenting a word).
REQ-013 rinc SHALL equal (state==FILL && !rempty), combinationally; rinc SHALL never be 1 while rempty=1.
REQ-014 Byte order SHALL be little-endian: the k-th popped byte of a word (k=0..3) goes to out_data[8k+7:8k], and a 2-bit byte_cnt tracks k.
REQ-015 Byte lanes not yet written SHALL read 0 in out_data, and the matching out_keep bits SHALL be 0.
REQ-016 At the edge where the 4th byte is popped, the block SHALL enter HOLD with out_keep=4'hF and byte_cnt=0.
REQ-017 In HOLD, out_valid SHALL be 1, rinc SHALL be 0, and out_data/out_keep SHALL stay stable until out_valid && out_ready is sampled at an edge.
REQ-018 On the accepting edge, the block SHALL return to FILL and clear out_data to 0 and out_keep to 0; out_valid SHALL be 0 in the following cycle.
REQ-019 out_valid SHALL be 0 in FILL.
REQ-020 Full-word throughput SHALL be at most one word per 5 rclk cycles: 4 pops plus 1 HOLD cycle when out_ready=1.
REQ-021 An 8-bit idle_cnt SHALL increment on each FILL edge where byte_cnt!=0 and rempty=1.
REQ-022 idle_cnt SHALL clear on any pop, on entry to HOLD, and whenever byte_cnt=0.
REQ-023 Flush: with TIMEOUT!=0, at an FILL edge where byte_cnt!=0, rempty=1 and idle_cnt==TIMEOUT-1, the block SHALL enter HOLD holding the partial word.
REQ-024 On flush, out_keep SHALL be {0..,1} covering the bytes collected (e.g. 2 bytes -> 4'h3), and byte_cnt SHALL clear.
REQ-025 Net flush timing SHALL be: out_valid rises after exactly TIMEOUT consecutive empty cycles following the last pop.
REQ-026 If rempty falls on the same edge the flush condition is met, the flush SHALL take priority and rinc SHALL be 0 that cycle, because the state is already HOLD.
REQ-027 A partial word SHALL never be emitted without the timeout; with TIMEOUT=0, partial bytes SHALL be held indefinitely.
REQ-028 No byte SHALL be lost or duplicated across any sequence of rempty/out_ready.

Reset
REQ-029 While rrst_n=0: state=FILL, byte_cnt=0, idle_cnt=0, out_data=0, out_keep=0, out_valid=0; rinc=0 is forced regardless of rempty.
REQ-030 Reset SHALL take effect asynchronously and be released synchronously to rclk by the integrating level.
REQ-031 Reset mid-word or in HOLD SHALL discard the partial or pending word; bytes already popped are lost, by design.

Verification
REQ-032 Scenario: TIMEOUT=16, FIFO supplies 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> rinc high for 4 cycles, then out_valid=1 for 1 cycle with out_data=0x44332211 and out_keep=4'hF.
REQ-033 Scenario: full word pending, out_ready=0 for 10 cycles with FIFO non-empty -> rinc=0 throughout, out_data stable, no byte consumed; the word is accepted on the cycle out_ready=1.
REQ-034 Scenario: 0xAA,0xBB popped, then rempty=1 -> out_valid rises after 16 empty cycles with out_data=0x0000BBAA and out_keep=4'h3.
REQ-035 Scenario: 1 byte popped, rempty=1 for 14 cycles, then a byte arrives -> no flush, idle_cnt cleared, and collection continues to byte_cnt=2.
REQ-036 Scenario: rrst_n pulsed low after 3 bytes popped -> all outputs 0 immediately; the next 4 bytes 0x01..0x04 yield out_data=0x04030201.
REQ-037 Scenario: rempty=1 from reset for 100 cycles -> rinc=0 and out_valid=0 throughout.
REQ-038 Concurrent checks: rinc |-> !rempty, out_data stable while out_valid && !out_ready, and out_data has no X when out_valid=1.
